// File: rtl/uart_pkg.sv
// +------------------------------------------------------------------+
// | uart_pkg : shared constants and FSM state type for uart_link     |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
`default_nettype none

package uart_pkg;
  localparam int   DEFAULT_CLKS_PER_BIT = 35;
  localparam int   DATA_BITS            = 8;
  localparam logic LINE_IDLE            = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;
endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// +------------------------------------------------------------------+
// | uart_bit_timer : loadable down-counter, one-cycle bit_tick_o     |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
`default_nettype none

module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic load_i,
  input  logic half_i,
  output logic bit_tick_o
);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] count_q, count_d;

  // Ticks on the last cycle of each period and reloads a full period itself
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = half_i ? HALF_LOAD : FULL_LOAD;
    end else if (en_i) begin
      count_d = (count_q == '0) ? FULL_LOAD : count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= FULL_LOAD;
    else       count_q <= count_d;
  end

  assign bit_tick_o = en_i && (count_q == '0);
endmodule

`default_nettype wire

// File: rtl/uart_link.sv
// +------------------------------------------------------------------+
// | uart_link : 8N1 UART, change-triggered TX, oversampled RX        |
// | Option   : define UART_PARITY_EN to add an even-parity bit       |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
`default_nettype none

module uart_link
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data_in,
  output logic                 tx_serial,
  output logic                 tx_busy,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_e          tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, last_sent_q, last_sent_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic                 tx_serial_q, tx_serial_d, tx_busy_q, tx_busy_d;
  logic                 tx_load, tx_tick;

  uart_state_e          rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;
  logic                 rx_parity_err_q, rx_parity_err_d;
  logic                 rx_load, rx_tick, rx_fall;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clock(clock), .reset(reset), .en_i(tx_state_q != IDLE),
    .load_i(tx_load), .half_i(1'b0), .bit_tick_o(tx_tick)
  );

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clock(clock), .reset(reset), .en_i(rx_state_q != IDLE),
    .load_i(rx_load), .half_i(1'b1), .bit_tick_o(rx_tick)
  );

  // last_sent_q holds the byte in flight, so parity is taken from it
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_shift_d  = tx_shift_q;
    last_sent_d = last_sent_q;
    tx_idx_d    = tx_idx_q;
    tx_serial_d = tx_serial_q;
    tx_busy_d   = tx_busy_q;
    tx_load     = 1'b0;
    case (tx_state_q)
      IDLE: if (tx_data_in != last_sent_q) begin
        tx_state_d  = START;
        tx_shift_d  = tx_data_in;
        last_sent_d = tx_data_in;
        tx_serial_d = 1'b0;
        tx_busy_d   = 1'b1;
        tx_load     = 1'b1;
      end
      START: if (tx_tick) begin
        tx_state_d  = DATA;
        tx_serial_d = tx_shift_q[0];
        tx_shift_d  = tx_shift_q >> 1;
        tx_idx_d    = '0;
      end
      DATA: if (tx_tick) begin
        if (tx_idx_q == LAST_IDX) begin
`ifdef UART_PARITY_EN
          tx_state_d  = PARITY;
          tx_serial_d = ^last_sent_q;
`else
          tx_state_d  = STOP;
          tx_serial_d = LINE_IDLE;
`endif
        end else begin
          tx_serial_d = tx_shift_q[0];
          tx_shift_d  = tx_shift_q >> 1;
          tx_idx_d    = tx_idx_q + 3'd1;
        end
      end
      PARITY: if (tx_tick) begin
        tx_state_d  = STOP;
        tx_serial_d = LINE_IDLE;
      end
      STOP: if (tx_tick) begin
        tx_state_d = IDLE;
        tx_busy_d  = 1'b0;
      end
      default: tx_state_d = IDLE;
    endcase
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  always_comb begin
    rx_state_d      = rx_state_q;
    rx_shift_d      = rx_shift_q;
    rx_data_d       = rx_data_q;
    rx_idx_d        = rx_idx_q;
    rx_perr_d       = rx_perr_q;
    rx_valid_d      = 1'b0;
    rx_ferr_d       = 1'b0;
    rx_parity_err_d = 1'b0;
    rx_load         = 1'b0;
    case (rx_state_q)
      IDLE: if (rx_fall) begin
        rx_state_d = START;
        rx_load    = 1'b1;
        rx_perr_d  = 1'b0;
      end
      START: if (rx_tick) begin
        rx_state_d = rx_sync_q ? IDLE : DATA;
        rx_idx_d   = '0;
      end
      DATA: if (rx_tick) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        rx_idx_d   = rx_idx_q + 3'd1;
        if (rx_idx_q == LAST_IDX) begin
`ifdef UART_PARITY_EN
          rx_state_d = PARITY;
`else
          rx_state_d = STOP;
`endif
        end
      end
      PARITY: if (rx_tick) begin
        rx_state_d = STOP;
        rx_perr_d  = rx_sync_q ^ (^rx_shift_q);
      end
      STOP: if (rx_tick) begin
        rx_state_d = IDLE;
        rx_ferr_d  = ~rx_sync_q;
`ifdef UART_PARITY_EN
        rx_parity_err_d = rx_perr_q;
`endif
        if (rx_sync_q && !rx_perr_q) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q      <= IDLE;
      tx_shift_q      <= '0;
      last_sent_q     <= '0;
      tx_idx_q        <= '0;
      tx_serial_q     <= LINE_IDLE;
      tx_busy_q       <= 1'b0;
      rx_state_q      <= IDLE;
      rx_shift_q      <= '0;
      rx_data_q       <= '0;
      rx_idx_q        <= '0;
      rx_meta_q       <= LINE_IDLE;
      rx_sync_q       <= LINE_IDLE;
      rx_prev_q       <= LINE_IDLE;
      rx_perr_q       <= 1'b0;
      rx_valid_q      <= 1'b0;
      rx_ferr_q       <= 1'b0;
      rx_parity_err_q <= 1'b0;
    end else begin
      tx_state_q      <= tx_state_d;
      tx_shift_q      <= tx_shift_d;
      last_sent_q     <= last_sent_d;
      tx_idx_q        <= tx_idx_d;
      tx_serial_q     <= tx_serial_d;
      tx_busy_q       <= tx_busy_d;
      rx_state_q      <= rx_state_d;
      rx_shift_q      <= rx_shift_d;
      rx_data_q       <= rx_data_d;
      rx_idx_q        <= rx_idx_d;
      rx_meta_q       <= rx_serial;
      rx_sync_q       <= rx_meta_q;
      rx_prev_q       <= rx_sync_q;
      rx_perr_q       <= rx_perr_d;
      rx_valid_q      <= rx_valid_d;
      rx_ferr_q       <= rx_ferr_d;
      rx_parity_err_q <= rx_parity_err_d;
    end
  end

  assign tx_serial     = tx_serial_q;
  assign tx_busy       = tx_busy_q;
  assign rx_data_out   = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_parity_err = rx_parity_err_q;
endmodule

`default_nettype wire

// File: tb/tb_uart_link.sv
// +------------------------------------------------------------------+
// | tb_uart_link : self-checking bench for uart_link                 |
// | Rev 1.0  : initial release                                       |
// +------------------------------------------------------------------+
`default_nettype none

module tb_uart_link;
  localparam int CPB = 35;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data_in;
  logic       tx_serial, tx_busy, rx_serial;
  logic [7:0] rx_data_out;
  logic       rx_valid, rx_frame_err, rx_parity_err;
  logic       loop_en, rx_drv;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  logic [7:0] last_good;

  assign rx_serial = loop_en ? tx_serial : rx_drv;

  uart_link #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .tx_data_in(tx_data_in),
    .tx_serial(tx_serial), .tx_busy(tx_busy), .rx_serial(rx_serial),
    .rx_data_out(rx_data_out), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
  );

  always #5 clock = ~clock;

  // Pulses last one full cycle, so each is seen at exactly one falling edge
  always @(negedge clock) begin
    if (rx_valid === 1'b1)      valid_cnt++;
    if (rx_frame_err === 1'b1)  ferr_cnt++;
    if (rx_parity_err === 1'b1) perr_cnt++;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected line levels of one frame, index 0 = start bit
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic flip_par, input logic stop_val);
    logic [10:0] f;
    f = frame_bits(b);
    if (flip_par) f[9] = ~f[9];
    f[NBITS-1] = stop_val;
    for (int i = 0; i < NBITS; i++) begin
      rx_drv = f[i];
      tick(CPB);
    end
    rx_drv = 1'b1;
    tick(CPB);
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b1; tx_data_in = 8'h00; loop_en = 1'b1; rx_drv = 1'b1;
    tick(3);
    checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL reset_tx_serial: got %b expected 1", tx_serial); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
    checks++; if (rx_data_out !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data_out); end
    checks++; if ({rx_valid, rx_frame_err, rx_parity_err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000", {rx_valid, rx_frame_err, rx_parity_err}); end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20 * CPB; i++) begin
      tick(1);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL zero_not_sent: %0d active cycles, expected 0", bad); end
    last_good = 8'h00;
  endtask

  task automatic test_tx_frame(input logic [7:0] b);
    logic [10:0] f;
    int bad, v0;
    f = frame_bits(b);
    v0 = valid_cnt;
    tx_data_in = b;
    tick(1);
    for (int k = 0; k < NBITS; k++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx_serial !== f[k] || tx_busy !== 1'b1) bad++;
        tick(1);
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL tx_bit%0d: %0d wrong cycles, expected level %b", k, bad, f[k]); end
    end
    checks++; if (tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
      errors++; $display("FAIL tx_end: busy=%b serial=%b expected busy=0 serial=1", tx_busy, tx_serial); end
    checks++; if (valid_cnt != v0 + 1 || rx_data_out !== b) begin
      errors++; $display("FAIL tx_loop_rx: valids=%0d data=%h expected valids=1 data=%h", valid_cnt - v0, rx_data_out, b); end
    last_good = b;
  endtask

  task automatic test_loopback;
    logic [7:0] seq [$];
    logic [7:0] b, prev;
    int t, v0, lat2;
    seq = '{8'd12, 8'd45, 8'd9, 8'd67, 8'd101};
    prev = 8'd101;
    for (int i = 0; i < 6; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == prev);
      seq.push_back(b);
      prev = b;
    end
    lat2 = (2 * NBITS - 1) * CPB + 6;
    v0 = valid_cnt;
    foreach (seq[i]) begin
      tx_data_in = seq[i];
      tick(1);
      t = 0;
      while (rx_valid !== 1'b1 && t < 12 * CPB) begin tick(1); t++; end
      checks++; if (rx_valid !== 1'b1 || rx_data_out !== seq[i]) begin
        errors++; $display("FAIL loop_data[%0d]: got %h expected %h", i, rx_data_out, seq[i]); end
      checks++; if (2 * t > lat2 + 4 || 2 * t < lat2 - 4) begin
        errors++; $display("FAIL loop_latency[%0d]: got %0d cycles expected %0d/2 +-2", i, t, lat2); end
      tick(15 * CPB - t);
      last_good = seq[i];
    end
    checks++; if (valid_cnt != v0 + seq.size()) begin
      errors++; $display("FAIL loop_count: got %0d expected %0d", valid_cnt - v0, seq.size()); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, b, c;
    int t, v0, bad;
    a = last_good ^ 8'h5A; b = last_good ^ 8'hC3; c = last_good ^ 8'h3C;
    v0 = valid_cnt;
    tx_data_in = a;
    tick(1);
    tick(3 * CPB);
    tx_data_in = b;
    tick(CPB);
    tx_data_in = c;
    t = 0;
    while (tx_busy === 1'b1 && t < 12 * CPB) begin tick(1); t++; end
    checks++; if (tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: busy=%b serial=%b expected 0/1", tx_busy, tx_serial); end
    tick(1);
    checks++; if (tx_busy !== 1'b1 || tx_serial !== 1'b0) begin
      errors++; $display("FAIL b2b_relaunch: busy=%b serial=%b expected 1/0", tx_busy, tx_serial); end
    t = 0;
    while (rx_valid !== 1'b1 && t < 12 * CPB) begin tick(1); t++; end
    checks++; if (rx_valid !== 1'b1 || rx_data_out !== c) begin
      errors++; $display("FAIL b2b_latest: got %h expected %h", rx_data_out, c); end
    tick(5 * CPB);
    checks++; if (valid_cnt != v0 + 2) begin
      errors++; $display("FAIL b2b_count: got %0d expected 2", valid_cnt - v0); end
    last_good = c;
    bad = 0;
    for (int i = 0; i < 12 * CPB; i++) begin
      tick(1);
      if (tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL no_resend: %0d busy cycles expected 0", bad); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    rx_drv = 1'b1; loop_en = 1'b0;
    tick(4);
    v0 = valid_cnt; f0 = ferr_cnt;
    rx_drv = 1'b0;
    tick(5);
    rx_drv = 1'b1;
    tick(3 * CPB);
    checks++; if (valid_cnt != v0 || ferr_cnt != f0) begin
      errors++; $display("FAIL glitch: valids=%0d ferrs=%0d expected 0/0", valid_cnt - v0, ferr_cnt - f0); end
    drive_rx_frame(8'hA5, 1'b0, 1'b1);
    checks++; if (valid_cnt != v0 + 1 || rx_data_out !== 8'hA5) begin
      errors++; $display("FAIL glitch_recover: valids=%0d data=%h expected 1/a5", valid_cnt - v0, rx_data_out); end
    last_good = 8'hA5;
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    drive_rx_frame(8'h55, 1'b0, 1'b0);
    checks++; if (ferr_cnt != f0 + 1) begin errors++; $display("FAIL frame_err_pulse: got %0d expected 1", ferr_cnt - f0); end
    checks++; if (valid_cnt != v0 || rx_data_out !== last_good) begin
      errors++; $display("FAIL frame_err_hold: valids=%0d data=%h expected 0/%h", valid_cnt - v0, rx_data_out, last_good); end
  endtask

  task automatic test_reset_mid;
    int v0, bad;
    loop_en = 1'b1;
    tick(2);
    v0 = valid_cnt;
    tx_data_in = ~tx_data_in;
    tick(1);
    tick(5 * CPB + CPB / 2);
    reset = 1'b1; tx_data_in = 8'h00;
    tick(1);
    checks++; if (tx_serial !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: serial=%b busy=%b expected 1/0", tx_serial, tx_busy); end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12 * CPB; i++) begin
      tick(1);
      if (tx_busy !== 1'b0) bad++;
    end
    checks++; if (valid_cnt != v0 || bad != 0 || rx_data_out !== 8'h00) begin
      errors++; $display("FAIL mid_reset_rx: valids=%0d busy=%0d data=%h expected 0/0/00", valid_cnt - v0, bad, rx_data_out); end
    last_good = 8'h00;
  endtask

  task automatic test_parity;
`ifdef UART_PARITY_EN
    int t, v0, p0;
    loop_en = 1'b1;
    v0 = valid_cnt;
    tx_data_in = 8'h07;
    tick(1);
    tick(9 * CPB + CPB / 2);
    checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL parity_bit: got %b expected 1", tx_serial); end
    t = 0;
    while (rx_valid !== 1'b1 && t < 3 * CPB) begin tick(1); t++; end
    checks++; if (rx_valid !== 1'b1 || rx_data_out !== 8'h07) begin
      errors++; $display("FAIL parity_rx: got %h expected 07", rx_data_out); end
    tick(3 * CPB);
    rx_drv = 1'b1; loop_en = 1'b0;
    tick(2);
    v0 = valid_cnt; p0 = perr_cnt;
    drive_rx_frame(8'h07, 1'b1, 1'b1);
    checks++; if (perr_cnt != p0 + 1 || valid_cnt != v0 || rx_data_out !== 8'h07) begin
      errors++; $display("FAIL parity_err: perrs=%0d valids=%0d data=%h expected 1/0/07", perr_cnt - p0, valid_cnt - v0, rx_data_out); end
`else
    checks++; if (perr_cnt != 0) begin errors++; $display("FAIL parity_tied: got %0d pulses expected 0", perr_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_tx_frame(8'h2D);
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
